// File: rtl/conv_coef_ctrl.sv
// conv_coef_ctrl: shadow/active coefficient banks, committed on frame start.
// Optional readback port enabled by defining COEF_READBACK_EN.
module conv_coef_ctrl #(
  parameter int COEF_W = 16,
  parameter int M_WIDTH = 5,
  parameter int M_DEPTH = 5,
  parameter int FRAC_BITS = 8,
  localparam int N = M_WIDTH * M_DEPTH,
  localparam int CNT_W = $clog2(N + 1),
  localparam int ADDR_W = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vs_i,
  input  logic              coef_write_i,
  input  logic [COEF_W-1:0] coef_data_i,
  input  logic              coef_restart_i,
  output logic [COEF_W-1:0] coef_o [N-1:0],
  output logic [CNT_W-1:0]  load_cnt_o,
  output logic              shadow_full_o,
  output logic              coef_update_o,
`ifdef COEF_READBACK_EN
  output logic              overflow_o,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [COEF_W-1:0] rd_data_o
`else
  output logic              overflow_o
`endif
);
  localparam int CENTER = (M_DEPTH / 2) * M_WIDTH + M_WIDTH / 2;
  typedef enum logic {LOADING, FULL} state_t;
  state_t state, state_n;
  logic [COEF_W-1:0] shadow [N-1:0];
  logic [CNT_W-1:0] cnt_n;
  logic vs_d, swap, accept;
  assign swap = vs_i & ~vs_d & (state == FULL);
  assign accept = coef_write_i & ~coef_restart_i & (state == LOADING);
  assign shadow_full_o = (state == FULL);
  always_comb begin
    state_n = state;
    cnt_n = load_cnt_o;
    if (coef_restart_i || swap) begin
      state_n = LOADING;
      cnt_n = '0;
    end else if (accept) begin
      cnt_n = load_cnt_o + CNT_W'(1);
      state_n = (cnt_n == CNT_W'(N)) ? FULL : LOADING;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LOADING;
      load_cnt_o <= '0;
      vs_d <= 1'b0;
      coef_update_o <= 1'b0;
      overflow_o <= 1'b0;
      for (int i = 0; i < N; i++) begin
        shadow[i] <= '0;
        coef_o[i] <= (i == CENTER) ? COEF_W'(1 << FRAC_BITS) : '0;
      end
    end else begin
      state <= state_n;
      load_cnt_o <= cnt_n;
      vs_d <= vs_i;
      coef_update_o <= swap;
      // Restart both clears the flag and suppresses any concurrent write
      overflow_o <= coef_restart_i ? 1'b0 : (overflow_o | (coef_write_i & (state == FULL)));
      if (accept) shadow[load_cnt_o] <= coef_data_i;
      if (swap) coef_o <= shadow;
    end
  end
`ifdef COEF_READBACK_EN
  always_ff @(posedge clk) begin
    if (rst) rd_data_o <= '0;
    else rd_data_o <= (32'(rd_addr_i) < N) ? coef_o[rd_addr_i] : '0;
  end
`endif
endmodule
